// File: rtl/stream_median3.sv
// Avalon-ST 3-tap horizontal median pre-filter for 24-bit RGB video.
// One-word hold stage (H) with a left-neighbour register (P) and a registered source port.
module stream_median3 #(
  parameter int IMAGE_W     = 640,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [23:0]            sink_data,
  input  logic                   sink_valid,
  output logic                   sink_ready,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  output logic [23:0]            source_data,
  output logic                   source_valid,
  input  logic                   source_ready,
  output logic                   source_sop,
  output logic                   source_eop,
  input  logic                   mode,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int X_W = (IMAGE_W > 2) ? $clog2(IMAGE_W) : 2;
  localparam logic [X_W-1:0] X_LAST        = X_W'(IMAGE_W - 1);
  localparam logic [X_W-1:0] X_RIGHT_INNER = X_W'(IMAGE_W - 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state, next_state;

  logic [23:0]    h_data;
  logic           h_sop;
  logic           h_eop;
  logic [X_W-1:0] h_x;
  logic           h_pix;
  logic [23:0]    p_data;
  logic           pkt_video;
  logic [X_W-1:0] x_cnt;

  logic        out_free;
  logic        accept;
  logic        emit_run;
  logic        emit_flush;
  logic        filt_en;
  logic [23:0] med_data;
  logic [23:0] f_data;

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] m;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    m  = (hi < c) ? hi : c;
    return (lo > m) ? lo : m;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    out_free   = ~source_valid | source_ready;
    next_state = state;
    sink_ready = 1'b0;
    accept     = 1'b0;
    emit_run   = 1'b0;
    emit_flush = 1'b0;
    case (state)
      IDLE: begin
        sink_ready = ~reset & out_free;
        accept     = sink_valid & sink_ready;
        // A lone sop+eop word still needs its own flush to be emitted.
        if (accept) begin
          next_state = sink_eop ? FLUSH : RUN;
        end
      end
      RUN: begin
        sink_ready = ~reset & out_free;
        accept     = sink_valid & sink_ready;
        if (accept) begin
          emit_run = 1'b1;
          if (sink_eop) begin
            next_state = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          emit_flush = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // An incoming sop means H ends a packet that lost its eop, so H goes out raw.
  always_comb begin
    filt_en = mode & pkt_video & h_pix & ~h_eop & ~sink_sop &
              (h_x != '0) & (h_x <= X_RIGHT_INNER);
    for (int ch = 0; ch < 3; ch++) begin
      med_data[ch*8 +: 8] = med3(p_data[ch*8 +: 8], h_data[ch*8 +: 8], sink_data[ch*8 +: 8]);
    end
    f_data = filt_en ? med_data : h_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_data       <= '0;
      h_sop        <= 1'b0;
      h_eop        <= 1'b0;
      h_x          <= '0;
      h_pix        <= 1'b0;
      p_data       <= '0;
      pkt_video    <= 1'b0;
      x_cnt        <= '0;
      source_valid <= 1'b0;
      source_data  <= '0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      frame_count  <= '0;
    end else begin
      if (accept) begin
        p_data <= h_data;
        h_data <= sink_data;
        h_sop  <= sink_sop;
        h_eop  <= sink_eop;
        h_pix  <= ~sink_sop;
        if (sink_sop) begin
          pkt_video <= (sink_data[3:0] == 4'h0);
          h_x       <= '0;
          x_cnt     <= '0;
        end else begin
          h_x   <= x_cnt;
          x_cnt <= (x_cnt == X_LAST) ? '0 : x_cnt + 1'b1;
        end
      end

      if (emit_run) begin
        source_valid <= 1'b1;
        source_data  <= f_data;
        source_sop   <= h_sop;
        source_eop   <= h_eop;
      end else if (emit_flush) begin
        source_valid <= 1'b1;
        source_data  <= h_data;
        source_sop   <= h_sop;
        source_eop   <= 1'b1;
        if (pkt_video) begin
          frame_count <= frame_count + 1'b1;
        end
      end else if (source_ready) begin
        source_valid <= 1'b0;
      end
    end
  end

endmodule
